// File: rtl/tp_ram.sv
// tp_ram: single-clock simple dual-port RAM, one write port and one read port.
// The read is read-first and registered, followed by OUTPUT_REG extra output
// stages. Memory contents survive reset; only the read pipeline is cleared.
module tp_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned OUTPUT_REG = 2,
    parameter string       RAM_TYPE   = "register"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [DATA_WIDTH-1:0] data_rd
);

    // Read register plus the output stages; index OUTPUT_REG is the last one.
    localparam int unsigned STAGES = OUTPUT_REG + 1;

    logic [DATA_WIDTH-1:0] mem_rdata_c;
    logic [DATA_WIDTH-1:0] pipe [STAGES];

    // Storage array; only the storage-style attribute differs between branches.
    if (RAM_TYPE == "block") begin : g_block
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        // Write port: not reset, so writes during reset still land.
        always_ff @(posedge clk) begin
            if (en_wr) begin
                mem[addr_wr] <= data_wr;
            end
        end

        assign mem_rdata_c = mem[addr_rd];
    end else begin : g_register
        (* ram_style = "registers" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        // Write port: not reset, so writes during reset still land.
        always_ff @(posedge clk) begin
            if (en_wr) begin
                mem[addr_wr] <= data_wr;
            end
        end

        assign mem_rdata_c = mem[addr_rd];
    end

    // Read pipeline: stage 0 loads on en_rd (old data, hence read-first),
    // later stages shift every cycle; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (en_rd) begin
                pipe[0] <= mem_rdata_c;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign data_rd = pipe[OUTPUT_REG];

endmodule

// File: tb/tb_tp_ram.sv
// tb_tp_ram: three tp_ram builds (register/OR=2, block/OR=0, block/OR=4) on
// shared stimulus, checked against an array model of memory plus a timing rule:
// data_rd after edge n equals the read-register value of edge n-L, or 0 if a
// reset edge lies anywhere in [n-L, n].
module tb_tp_ram;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 4;
    localparam int unsigned NDUT = 3;
    localparam int          MAXC = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_wr;
    logic [AW-1:0] addr_wr;
    logic [DW-1:0] data_wr;
    logic          en_rd;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] data_rd_a;
    logic [DW-1:0] data_rd_b;
    logic [DW-1:0] data_rd_c;

    always #5 clk = ~clk;

    tp_ram #(.DEPTH(16), .DATA_WIDTH(DW), .OUTPUT_REG(2), .RAM_TYPE("register")) u_dut_a (
        .clk(clk), .rst(rst), .en_wr(en_wr), .addr_wr(addr_wr), .data_wr(data_wr),
        .en_rd(en_rd), .addr_rd(addr_rd), .data_rd(data_rd_a)
    );

    tp_ram #(.DEPTH(16), .DATA_WIDTH(DW), .OUTPUT_REG(0), .RAM_TYPE("block")) u_dut_b (
        .clk(clk), .rst(rst), .en_wr(en_wr), .addr_wr(addr_wr), .data_wr(data_wr),
        .en_rd(en_rd), .addr_rd(addr_rd), .data_rd(data_rd_b)
    );

    tp_ram #(.DEPTH(16), .DATA_WIDTH(DW), .OUTPUT_REG(4), .RAM_TYPE("block")) u_dut_c (
        .clk(clk), .rst(rst), .en_wr(en_wr), .addr_wr(addr_wr), .data_wr(data_wr),
        .en_rd(en_rd), .addr_rd(addr_rd), .data_rd(data_rd_c)
    );

    int lat [NDUT] = '{2, 0, 4};

    // Reference model state
    logic [DW-1:0] ref_mem     [16];
    bit            ref_written [16];
    logic [DW-1:0] rr_val      [MAXC];
    bit            rr_known    [MAXC];
    bit            rst_at      [MAXC];
    logic [DW-1:0] obs_hist    [NDUT][MAXC];
    int            n = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected data_rd after edge idx for a build with latency-1 = l; returns 0 if unknown.
    function automatic bit exp_at(input int idx, input int l, output logic [DW-1:0] v);
        v = '0;
        for (int k = idx - l; k <= idx; k++) begin
            if (k >= 0 && rst_at[k]) return 1'b1;
        end
        if (idx - l < 0) return 1'b0;
        v = rr_val[idx-l];
        return rr_known[idx-l];
    endfunction

    // Apply one cycle of inputs, advance the model by one edge, check all builds.
    task automatic step(input bit r, input bit we, input logic [AW-1:0] aw,
                        input logic [DW-1:0] dw, input bit re, input logic [AW-1:0] ar);
        logic [DW-1:0] ev;
        logic [DW-1:0] obs [NDUT];
        rst = r; en_wr = we; addr_wr = aw; data_wr = dw; en_rd = re; addr_rd = ar;
        @(posedge clk);
        if (n >= MAXC) begin
            $display("FAIL cycle_budget: got=%0d expected<%0d", n, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        rst_at[n] = r;
        if (r) begin
            rr_val[n] = '0; rr_known[n] = 1'b1;
        end else if (re) begin
            rr_val[n] = ref_mem[ar]; rr_known[n] = ref_written[ar];
        end else if (n > 0) begin
            rr_val[n] = rr_val[n-1]; rr_known[n] = rr_known[n-1];
        end else begin
            rr_val[n] = '0; rr_known[n] = 1'b0;
        end
        if (we) begin
            ref_mem[aw] = dw; ref_written[aw] = 1'b1;
        end
        #1;
        obs[0] = data_rd_a; obs[1] = data_rd_b; obs[2] = data_rd_c;
        for (int d = 0; d < NDUT; d++) begin
            obs_hist[d][n] = obs[d];
            if (exp_at(n, lat[d], ev)) begin
                chk($sformatf("model_L%0d_edge%0d", lat[d] + 1, n), obs[d], ev);
            end
        end
        n++;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        int e;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0; ref_written[i] = 1'b0;
        end
        rst = 1'b1; en_wr = 1'b0; addr_wr = '0; data_wr = '0; en_rd = 1'b0; addr_rd = '0;

        // Reset two cycles; outputs must read 0
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        chk("reset_a", obs_hist[0][1], 8'd0);
        chk("reset_b", obs_hist[1][1], 8'd0);
        chk("reset_c", obs_hist[2][1], 8'd0);

        // Fill addr i with i*10, then read back on consecutive cycles
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, AW'(i), DW'(i * 10), 1'b0, '0);
        e = n;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
        idle(5);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_a_%0d", i), obs_hist[0][e+i+2], DW'(i * 10));
            chk($sformatf("fill_b_%0d", i), obs_hist[1][e+i], DW'(i * 10));
            chk($sformatf("fill_c_%0d", i), obs_hist[2][e+i+4], DW'(i * 10));
        end

        // Read-first collision on addr 5, then re-read sees new value
        e = n;
        step(1'b0, 1'b1, 4'd5, 8'hAA, 1'b1, 4'd5);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
        idle(5);
        chk("rf_old_a", obs_hist[0][e+2], 8'd50);
        chk("rf_new_a", obs_hist[0][e+3], 8'hAA);
        chk("rf_old_b", obs_hist[1][e], 8'd50);
        chk("rf_new_b", obs_hist[1][e+1], 8'hAA);

        // Read addr 3 then hold en_rd low while addr_rd wanders
        e = n;
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0, 1'b0, AW'($urandom_range(0, 15)));
        for (int i = 2; i <= 5; i++) chk($sformatf("hold_a_%0d", i), obs_hist[0][e+i], 8'd30);
        for (int i = 0; i <= 5; i++) chk($sformatf("hold_b_%0d", i), obs_hist[1][e+i], 8'd30);

        // Reset mid-read flushes the pipeline; next read takes full latency
        e = n;
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd8);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd9);
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd9);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd7);
        idle(5);
        chk("flush_a0", obs_hist[0][e+2], 8'd0);
        chk("flush_a1", obs_hist[0][e+3], 8'd0);
        chk("flush_a2", obs_hist[0][e+4], 8'd0);
        chk("post_rst_a", obs_hist[0][e+5], 8'd70);
        chk("post_rst_b", obs_hist[1][e+3], 8'd70);
        chk("post_rst_c", obs_hist[2][e+7], 8'd70);

        // Write during reset must land; single-cycle build reads addr 2 next edge
        e = n;
        step(1'b1, 1'b1, 4'd12, 8'h5C, 1'b1, 4'd12);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd12);
        idle(5);
        chk("rst_rd_ignored_b", obs_hist[1][e], 8'd0);
        chk("or0_b", obs_hist[1][e+1], 8'd20);
        chk("rst_wr_b", obs_hist[1][e+2], 8'h5C);
        chk("rst_wr_a", obs_hist[0][e+4], 8'h5C);

        // Random mix, checked cycle by cycle against the model
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), AW'($urandom), DW'($urandom),
                 1'($urandom), AW'($urandom));
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
